// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: ROB commit record, commit FSM states and counter widths.
package ooo_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int PC_WIDTH       = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int INSTRET_WIDTH  = 64;

    typedef struct packed {
        logic        valid;
        logic [31:0] cause;
    } ooo_exception_t;

    typedef struct packed {
        logic                      valid;
        logic [PC_WIDTH-1:0]       pc;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic [DATA_WIDTH-1:0]     result;
        ooo_exception_t            exception;
    } ooo_commit_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        TRAP  = 2'd1,
        FLUSH = 2'd2
    } commit_state_e;

endpackage

// File: rtl/commit_unit_perf_counters.sv
// Retired-instruction and committed-exception counters for the commit stage.
// instret wraps; the exception count saturates at all-ones.
module commit_perf_counters
    import ooo_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     commit_fire,
    input  logic                     exc_fire,
    output logic [INSTRET_WIDTH-1:0] instret,
    output logic [31:0]              exc_count
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instret   <= '0;
            exc_count <= '0;
        end else begin
            if (commit_fire) instret <= instret + 1'b1;
            if (exc_fire && (exc_count != 32'hFFFF_FFFF)) exc_count <= exc_count + 1'b1;
        end
    end

endmodule

// File: rtl/commit_unit.sv
// ROB commit consumer: in-order retirement to the regfile, trap hand-off to CSR, then flush.
// Performance counters are built only when COMMIT_PERF_CNT_EN is defined.
module commit_unit
    import ooo_pkg::*;
#(
    parameter int DATA_WIDTH     = ooo_pkg::DATA_WIDTH,
    parameter int PC_WIDTH       = ooo_pkg::PC_WIDTH,
    parameter int REG_ADDR_WIDTH = ooo_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  ooo_commit_t               commit_i,
    output logic                      commit_ready_o,
    input  logic                      flush_req_i,
    output logic                      flush_o,
    output logic                      rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0]     rf_wdata_o,
    output logic                      trap_valid_o,
    output logic [PC_WIDTH-1:0]       trap_pc_o,
    output logic [31:0]               trap_cause_o,
    input  logic                      trap_ready_i,
    output logic [63:0]               instret_o,
    output logic [31:0]               exc_count_o
);

    commit_state_e state;
    logic          fire;

    assign commit_ready_o = (state == RUN) && !flush_req_i;
    assign fire           = commit_i.valid && commit_ready_o;
    assign flush_o        = (state == FLUSH) || flush_req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= RUN;
            rf_we_o      <= 1'b0;
            rf_waddr_o   <= '0;
            rf_wdata_o   <= '0;
            trap_valid_o <= 1'b0;
            trap_pc_o    <= '0;
            trap_cause_o <= '0;
        end else begin
            rf_we_o <= 1'b0;
            case (state)
                RUN: begin
                    if (fire) begin
                        if (commit_i.exception.valid) begin
                            trap_valid_o <= 1'b1;
                            trap_pc_o    <= commit_i.pc;
                            trap_cause_o <= commit_i.exception.cause;
                            state        <= TRAP;
                        end else begin
                            // x0 is hardwired zero: address/data still track, no write strobe.
                            rf_we_o    <= (commit_i.rd_addr != '0);
                            rf_waddr_o <= commit_i.rd_addr;
                            rf_wdata_o <= commit_i.result;
                        end
                    end
                end
                TRAP: begin
                    if (trap_ready_i) begin
                        trap_valid_o <= 1'b0;
                        state        <= FLUSH;
                    end
                end
                FLUSH:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef COMMIT_PERF_CNT_EN
    logic exc_fire;
    assign exc_fire = fire && commit_i.exception.valid;

    commit_perf_counters u_perf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .commit_fire (fire),
        .exc_fire    (exc_fire),
        .instret     (instret_o),
        .exc_count   (exc_count_o)
    );
`else
    assign instret_o   = '0;
    assign exc_count_o = '0;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: a small reference model plus a queue of expected regfile writes.
module tb_commit_unit;
    import ooo_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    ooo_commit_t cmt;
    logic        commit_ready_o, flush_req_i, flush_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        trap_valid_o;
    logic [31:0] trap_pc_o, trap_cause_o;
    logic        trap_ready_i;
    logic [63:0] instret_o;
    logic [31:0] exc_count_o;

    commit_unit dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .commit_i       (cmt),
        .commit_ready_o (commit_ready_o),
        .flush_req_i    (flush_req_i),
        .flush_o        (flush_o),
        .rf_we_o        (rf_we_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .trap_valid_o   (trap_valid_o),
        .trap_pc_o      (trap_pc_o),
        .trap_cause_o   (trap_cause_o),
        .trap_ready_i   (trap_ready_i),
        .instret_o      (instret_o),
        .exc_count_o    (exc_count_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    commit_state_e mstate;
    logic          mtv;
    logic [31:0]   mpc, mcause, mexc;
    logic [63:0]   minstret;
    logic [36:0]   wq[$];   // {addr, data}

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mstate = RUN; mtv = 0; mpc = 0; mcause = 0; mexc = 0; minstret = 0;
        wq.delete();
    endtask

    task automatic check_regs();
        logic [36:0] e;
        if (wq.size() > 0) begin
            e = wq.pop_front();
            chk("rf_we", rf_we_o, 1);
            chk("rf_waddr", rf_waddr_o, e[36:32]);
            chk("rf_wdata", rf_wdata_o, e[31:0]);
        end else
            chk("rf_we_idle", rf_we_o, 0);
        chk("trap_valid", trap_valid_o, mtv);
        if (mtv) begin
            chk("trap_pc", trap_pc_o, mpc);
            chk("trap_cause", trap_cause_o, mcause);
        end
`ifdef COMMIT_PERF_CNT_EN
        chk("instret", instret_o, minstret);
        chk("exc_count", exc_count_o, mexc);
`else
        chk("instret", instret_o, 0);
        chk("exc_count", exc_count_o, 0);
`endif
    endtask

    // Drive one cycle of stimulus at posedge+1, check comb outputs, then registered ones.
    task automatic step(input logic v, input logic [4:0] rd, input logic [31:0] res,
                        input logic ex, input logic [31:0] pc, input logic [31:0] cause,
                        input logic fr, input logic tr);
        logic ready, fire;
        cmt.valid = v; cmt.rd_addr = rd; cmt.result = res; cmt.pc = pc;
        cmt.exception.valid = ex; cmt.exception.cause = cause;
        flush_req_i = fr; trap_ready_i = tr;
        #1;
        ready = (mstate == RUN) && !fr;
        fire  = v && ready;
        chk("commit_ready", commit_ready_o, ready);
        chk("flush", flush_o, (mstate == FLUSH) || fr);
        if (fire) begin
            minstret++;
            if (ex) begin
                if (mexc != 32'hFFFF_FFFF) mexc++;
                mtv = 1; mpc = pc; mcause = cause; mstate = TRAP;
            end else if (rd != 0)
                wq.push_back({rd, res});
        end else if (mstate == TRAP && tr) begin
            mtv = 0; mstate = FLUSH;
        end else if (mstate == FLUSH)
            mstate = RUN;
        @(posedge clk_i); #1;
        check_regs();
    endtask

    task automatic idle(input logic tr);
        step(0, 0, 0, 0, 0, 0, 0, tr);
    endtask

    initial begin
        rst_ni = 0; flush_req_i = 0; trap_ready_i = 0; cmt = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", commit_ready_o, 1);
        chk("rst_flush", flush_o, 0);
        check_regs();
        rst_ni = 1;

        // back-to-back commits, then idle
        step(1, 5'd5, 32'hDEAD, 0, 32'h100, 0, 0, 0);
        step(1, 5'd6, 32'hBEEF, 0, 32'h104, 0, 0, 0);
        idle(0);
        // x0 destination: counted, never written
        step(1, 5'd0, 32'h1234, 0, 32'h108, 0, 0, 0);
        // trap_ready outside TRAP is ignored
        idle(1);
        // excepting commit with CSR stalling three cycles
        step(1, 5'd7, 32'h5555, 1, 32'h8000_0010, 32'd2, 0, 0);
        repeat (3) idle(0);
        step(1, 5'd8, 32'h7777, 0, 32'h200, 0, 1, 0);   // flush_req does not abort TRAP
        idle(1);                                         // CSR accepts
        step(1, 5'd9, 32'h9999, 0, 32'h204, 0, 0, 0);   // FLUSH cycle: not ready
        step(1, 5'd9, 32'h9999, 0, 32'h204, 0, 0, 0);   // back in RUN
        // external flush with a valid commit pending
        step(1, 5'd10, 32'hAAAA, 0, 32'h208, 0, 1, 0);
        step(1, 5'd11, 32'hBBBB, 0, 32'h20C, 0, 0, 0);
        idle(0);

        // reset asserted mid-TRAP
        step(1, 5'd12, 32'h0, 1, 32'h8000_0020, 32'd5, 0, 0);
        idle(0);
        rst_ni = 0; cmt = '0;
        #1;
        chk("rst_trap_valid", trap_valid_o, 0);
        chk("rst_trap_flush", flush_o, 0);
        model_reset();
        @(posedge clk_i); #1;
        rst_ni = 1;
        #1;
        chk("post_rst_ready", commit_ready_o, 1);
        check_regs();
        step(1, 5'd13, 32'hCAFE, 0, 32'h300, 0, 0, 0);
        idle(0);
        chk("queue_drained", wq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
